cmp_sort_ctrl: RTL and testbench



---
 rtl/cmp_sort_ctrl_pkg.sv | 13 +
 rtl/cmp_signed_gt.sv | 12 +
 rtl/cmp_sort_ctrl.sv | 137 +++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sort_ctrl_pkg.sv
// rtl/cmp_sort_ctrl_pkg.sv - shared state encodings and default sizes for the sort sequencer
package cmp_sort_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_SORT = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   localparam int DEF_N = 8;
   localparam int DEF_W = 4;

endpackage

// File: rtl/cmp_signed_gt.sv
// rtl/cmp_signed_gt.sv - shared combinational signed greater-than comparator
module cmp_signed_gt #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt
);

   assign gt = $signed(a) > $signed(b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - load/bubble-sort/drain sequencer around one shared signed comparator
module cmp_sort_ctrl
   import cmp_sort_ctrl_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
   localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

   state_t        state;
   state_t        state_nx;
   logic [W-1:0]  mem [N];
   logic [IW-1:0] wr_ptr;
   logic [IW-1:0] rd_ptr;
   logic [IW-1:0] pass_i;
   logic [IW-1:0] idx_j;
   logic [IW-1:0] idx_j1;
   logic          gt;
   logic          in_fire;
   logic          out_fire;
   logic          pass_end;
   logic          sort_end;

   assign idx_j1 = idx_j + IW'(1);

   cmp_signed_gt #(.W(W)) u_cmp (
      .a  (mem[idx_j]),
      .b  (mem[idx_j1]),
      .gt (gt)
   );

   // Handshakes qualify on state only, so no input reaches an output combinationally.
   assign in_fire  = in_valid  && (state == ST_LOAD);
   assign out_fire = out_ready && (state == ST_OUT);
   assign pass_end = (idx_j == (LAST_PASS - pass_i));
   assign sort_end = pass_end && (pass_i == LAST_PASS);

   assign out_data = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_fire && (wr_ptr == LAST_IDX)) begin
               state_nx = ST_SORT;
            end
         end
         ST_SORT: begin
            busy = 1'b1;
            if (sort_end) begin
               state_nx = ST_OUT;
            end
         end
         ST_OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_fire && (rd_ptr == LAST_IDX)) begin
               state_nx = ST_LOAD;
            end
         end
         default: begin
            state_nx = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pass_i <= '0;
         idx_j  <= '0;
         for (int k = 0; k < N; k++) begin
            mem[k] <= '0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_fire) begin
                  mem[wr_ptr] <= in_data;
                  wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + IW'(1);
               end
            end
            ST_SORT: begin
               // Fixed schedule: every pair is visited even if already ordered.
               if (gt) begin
                  mem[idx_j]  <= mem[idx_j1];
                  mem[idx_j1] <= mem[idx_j];
               end
               if (pass_end) begin
                  idx_j  <= '0;
                  pass_i <= sort_end ? '0 : pass_i + IW'(1);
               end else begin
                  idx_j <= idx_j1;
               end
            end
            ST_OUT: begin
               if (out_fire) begin
                  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + IW'(1);
               end
            end
            default: begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               pass_i <= '0;
               idx_j  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - directed self-checking bench for cmp_sort_ctrl (N=8 and N=2 instances)
module tb_cmp_sort_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic       busy;

   logic       in_valid2 = 1'b0;
   logic       in_ready2;
   logic [3:0] in_data2 = 4'h0;
   logic       out_valid2;
   logic       out_ready2 = 1'b0;
   logic [3:0] out_data2;
   logic       busy2;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] vin [8];
   logic [3:0] vexp [8];

   always #5 clk = ~clk;

   cmp_sort_ctrl #(.N(8), .W(4)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   cmp_sort_ctrl #(.N(2), .W(4)) dut2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .busy(busy2)
   );

   task automatic load8();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_in_ready k=%0d got=%b want=1", k, in_ready);
         end
         in_valid = 1'b1;
         in_data  = vin[k];
      end
   endtask

   task automatic wait_out8(input bit hold, input int lat);
      int k;
      bit bad_ready = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL sort_busy got=%b want=1", busy);
            end
         end
         if (out_valid === 1'b1) break;
         if (in_ready !== 1'b0) bad_ready = 1'b1;
         in_valid = hold;
         in_data  = 4'h5;
      end
      in_valid = 1'b0;
      vectors++;
      if (k != lat) begin
         miscompares++;
         $display("FAIL sort_latency got=%0d want=%0d", k, lat);
      end
      vectors++;
      if (bad_ready) begin
         miscompares++;
         $display("FAIL sort_in_ready got=1 want=0");
      end
   endtask

   task automatic drain8(input bit bp);
      int idx = 0;
      int iter = 0;
      logic [3:0] pat;
      pat = 4'b1001;
      while (idx < 8 && iter < 64) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || out_data !== vexp[idx]) begin
            miscompares++;
            $display("FAIL drain_data idx=%0d got=%h/%b want=%h/1", idx, out_data, out_valid, vexp[idx]);
         end
         vectors++;
         if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_in_ready got=%b want=0", in_ready);
         end
         out_ready = bp ? pat[3 - (iter % 4)] : 1'b1;
         if (out_ready) idx++;
         iter++;
      end
      @(negedge clk);
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_end got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_n8 got ir=%b ov=%b busy=%b od=%h want 1/0/0/0", in_ready, out_valid, busy, out_data);
      end
      vectors++;
      if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || busy2 !== 1'b0 || out_data2 !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_n2 got ir=%b ov=%b busy=%b od=%h want 1/0/0/0", in_ready2, out_valid2, busy2, out_data2);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic_sort();
      vin  = '{4'h3, 4'hE, 4'h7, 4'h0, 4'h8, 4'h5, 4'hF, 4'h2};
      vexp = '{4'h8, 4'hE, 4'hF, 4'h0, 4'h2, 4'h3, 4'h5, 4'h7};
      load8();
      wait_out8(1'b0, 29);
      drain8(1'b0);
   endtask

   task automatic test_duplicates_signed();
      vin  = '{4'h7, 4'h8, 4'h7, 4'hF, 4'h8, 4'h0, 4'hF, 4'h7};
      vexp = '{4'h8, 4'h8, 4'hF, 4'hF, 4'h0, 4'h7, 4'h7, 4'h7};
      load8();
      wait_out8(1'b0, 29);
      drain8(1'b0);
   endtask

   task automatic test_backpressure();
      vin  = '{4'h3, 4'hE, 4'h7, 4'h0, 4'h8, 4'h5, 4'hF, 4'h2};
      vexp = '{4'h8, 4'hE, 4'hF, 4'h0, 4'h2, 4'h3, 4'h5, 4'h7};
      load8();
      wait_out8(1'b1, 29);
      drain8(1'b1);
   endtask

   task automatic test_reset_mid_sort();
      vin = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0};
      load8();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'h0) begin
         miscompares++;
         $display("FAIL mid_sort_reset got ir=%b busy=%b ov=%b od=%h want 1/0/0/0", in_ready, busy, out_valid, out_data);
      end
      reset = 1'b0;
      vin  = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
      vexp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
      load8();
      wait_out8(1'b0, 29);
      drain8(1'b0);
   endtask

   task automatic burst2(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] lo, input logic [3:0] hi);
      int k;
      logic [3:0] want;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         vectors++;
         if (in_ready2 !== 1'b1) begin
            miscompares++;
            $display("FAIL n2_in_ready n=%0d got=%b want=1", n, in_ready2);
         end
         in_valid2 = 1'b1;
         in_data2  = (n == 0) ? a : b;
      end
      for (k = 1; k <= 8; k++) begin
         @(negedge clk);
         in_valid2 = 1'b0;
         if (out_valid2 === 1'b1) break;
      end
      vectors++;
      if (k != 2) begin
         miscompares++;
         $display("FAIL n2_latency got=%0d want=2", k);
      end
      for (int n = 0; n < 2; n++) begin
         if (n == 1) @(negedge clk);
         want = (n == 0) ? lo : hi;
         vectors++;
         if (out_valid2 !== 1'b1 || out_data2 !== want) begin
            miscompares++;
            $display("FAIL n2_data n=%0d got=%h/%b want=%h/1", n, out_data2, out_valid2, want);
         end
         out_ready2 = 1'b1;
      end
   endtask

   task automatic test_n2_back_to_back();
      burst2(4'h1, 4'hF, 4'hF, 4'h1);
      burst2(4'hE, 4'h3, 4'hE, 4'h3);
      burst2(4'h5, 4'hC, 4'hC, 4'h5);
      @(negedge clk);
      out_ready2 = 1'b0;
      vectors++;
      if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || busy2 !== 1'b0) begin
         miscompares++;
         $display("FAIL n2_end got ov=%b ir=%b busy=%b want 0/1/0", out_valid2, in_ready2, busy2);
      end
   endtask

   initial begin
      test_reset();
      test_basic_sort();
      test_duplicates_signed();
      test_backpressure();
      test_reset_mid_sort();
      test_n2_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
